regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width (2^ADDR_W = 32 registers).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port we  input  1  write enable for the write port.
REQ-006 SHALL have port waddr  input  ADDR_W  write address, driven by the 5-bit destination-select mux (rd/rt).
REQ-007 SHALL have port wdata  input  DATA_W  write data.
REQ-008 SHALL have port raddr1 / raddr2  input  ADDR_W each  read addresses (rs, rt).
REQ-009 SHALL have port rdata1 / rdata2  output  DATA_W each  read data.
REQ-010 SHALL have port mark_en  input  1  marks a register as pending (in-flight producer issued).
REQ-011 SHALL have port mark_addr  input  ADDR_W  register to mark pending.
REQ-012 SHALL have port busy1 / busy2  output  1 each  pending flag for raddr1 / raddr2.
REQ-013 SHALL have port busy_cnt  output  ADDR_W+1  number of registers currently pending.

Function
REQ-014 SHALL hold 32 registers of DATA_W bits plus a 32-bit pending vector.
REQ-015 Register 0 SHALL always read 0, never be written, and never be pending; we or mark_en with address 0 SHALL be ignored.
REQ-016 On rising clk with we=1 and waddr!=0: reg[waddr] <= wdata; pending[waddr] <= 0.
REQ-017 On rising clk with mark_en=1 and mark_addr!=0: pending[mark_addr] <= 1.
REQ-018 Simultaneous write and mark to the same nonzero address: data SHALL be written and pending SHALL end at 1 (mark wins, newer producer).
REQ-019 Simultaneous write and mark to different addresses SHALL both take effect in the same cycle.
REQ-020 Marking an already-pending register SHALL leave it pending and SHALL NOT change busy_cnt.
REQ-021 Writing a non-pending register SHALL leave it non-pending.
REQ-022 Reads are combinational, zero latency: rdataN = 0 if raddrN==0; else wdata if we=1 and waddr==raddrN (write-through bypass); else reg[raddrN].
REQ-023 busyN (combinational) = pending[raddrN] AND NOT (we=1 AND waddr==raddrN); busyN = 0 when raddrN==0.
REQ-024 busy_cnt SHALL equal the population count of the registered pending vector (range 0..31); it reflects updates the cycle after the clock edge that causes them.
REQ-025 Both read ports SHALL be independent; raddr1==raddr2 SHALL return identical data and busy.

Reset
REQ-026 While rst=1 at a rising edge: all registers <= 0, pending <= 0; we and mark_en SHALL be ignored in that cycle.
REQ-027 After reset: rdata1=rdata2=0 for all addresses with we=0, busy1=busy2=0, busy_cnt=0.
REQ-028 rst asserted mid-operation SHALL discard all pending marks and stored data on that edge, with no partial update.

Verification
REQ-029 Reset, then we=1 waddr=5 wdata=0xDEADBEEF; next cycle raddr1=5 -> rdata1=0xDEADBEEF; same cycle as write raddr2=5 -> rdata2=0xDEADBEEF (bypass).
REQ-030 we=1 waddr=0 wdata=0x12345678, mark_en=1 mark_addr=0 -> raddr1=0 gives rdata1=0, busy1=0, busy_cnt=0.
REQ-031 mark 3, then mark 7, then mark 3 again -> busy_cnt 1, 2, 2; raddr1=3 -> busy1=1; we=1 waddr=3 wdata=0xA -> busy1=0 combinationally that cycle, busy_cnt=1 next cycle.
REQ-032 Same edge: we=1 waddr=9 wdata=0x55, mark_en=1 mark_addr=9 -> next cycle rdata1(raddr1=9)=0x55, busy1=1, busy_cnt incremented by 1.
REQ-033 Write 0x1..0x1F to r1..r31 and mark all -> busy_cnt=31; assert rst one cycle -> all reads 0, busy_cnt=0.

Source files
------------

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb -- register file with a per-register scoreboard (pending bits)
//
// Holds 2^ADDR_W registers of DATA_W bits and one pending flag per register.
// A pending flag is set when an in-flight producer is issued for that
// register (mark_en) and cleared when its result is written back (we).
// Register 0 is hardwired: it reads 0, ignores writes and is never pending.
//
// Ports
//   clk        : single clock, all state updates on the rising edge
//   rst        : synchronous, active-high reset (clears data and pending)
//   we         : write enable
//   waddr      : write address (destination register)
//   wdata      : write data
//   raddr1/2   : read addresses (rs / rt)
//   rdata1/2   : combinational read data, with write-through bypass
//   mark_en    : set the pending flag of mark_addr
//   mark_addr  : register to mark pending
//   busy1/2    : pending flag of raddr1/2, masked by a same-cycle write
//   busy_cnt   : number of registers whose registered pending flag is set
// ---------------------------------------------------------------------------
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              mark_en,
    input  logic [ADDR_W-1:0] mark_addr,
    output logic              busy1,
    output logic              busy2,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int NREG  = 1 << ADDR_W;
    localparam int NPORT = 2;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] regs_reg [NREG];
    logic [NREG-1:0]   pending_reg;

    logic wr_ok;
    logic mk_ok;

    // Address 0 is filtered here so that entry 0 stays at its reset value
    // forever and the pending bit of r0 can never be set.
    assign wr_ok = we      && (waddr     != '0);
    assign mk_ok = mark_en && (mark_addr != '0);

    // The mark is applied after the write-back clear, so when both target
    // the same register the newer producer wins and the flag ends up set.
    // Reset takes priority over everything: no partial update on that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
            pending_reg <= '0;
        end else begin
            if (wr_ok) begin
                regs_reg[waddr]    <= wdata;
                pending_reg[waddr] <= 1'b0;
            end
            if (mk_ok) begin
                pending_reg[mark_addr] <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read ports (identical, independent logic per port)
    // -----------------------------------------------------------------------
    logic [NPORT-1:0][ADDR_W-1:0] raddr_p;
    logic [NPORT-1:0][DATA_W-1:0] rdata_p;
    logic [NPORT-1:0]             busy_p;
    logic [NPORT-1:0]             rd_zero;
    logic [NPORT-1:0]             rd_hit;

    assign raddr_p[0] = raddr1;
    assign raddr_p[1] = raddr2;

    genvar gi;
    generate
        for (gi = 0; gi < NPORT; gi++) begin : g_rport
            assign rd_zero[gi] = (raddr_p[gi] == '0);
            // A write to the address being read this cycle is forwarded
            // straight to the output and its result is no longer pending.
            assign rd_hit[gi]  = we && (waddr == raddr_p[gi]);

            assign rdata_p[gi] = rd_zero[gi] ? '0 :
                                 rd_hit[gi]  ? wdata :
                                               regs_reg[raddr_p[gi]];

            assign busy_p[gi]  = !rd_zero[gi] && !rd_hit[gi] &&
                                 pending_reg[raddr_p[gi]];
        end
    endgenerate

    assign rdata1 = rdata_p[0];
    assign rdata2 = rdata_p[1];
    assign busy1  = busy_p[0];
    assign busy2  = busy_p[1];

    // -----------------------------------------------------------------------
    // Pending population count, taken from the registered vector only so it
    // changes the cycle after the edge that sets or clears a flag.
    // -----------------------------------------------------------------------
    logic [ADDR_W:0] pop_cnt;

    always_comb begin
        pop_cnt = '0;
        for (int i = 1; i < NREG; i++) begin
            pop_cnt = pop_cnt + {{ADDR_W{1'b0}}, pending_reg[i]};
        end
    end

    assign busy_cnt = pop_cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb -- directed bench for regfile_sb
//
// The stimulus process drives one cycle of inputs shortly after each rising
// edge and pushes the hand-computed response for that cycle into a queue.
// The monitor pops one entry on each falling edge and compares the
// combinational outputs against it, field by field under a check mask.
// ---------------------------------------------------------------------------
module tb_regfile_sb;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] raddr1;
    logic [AW-1:0] raddr2;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] rdata2;
    logic          mark_en;
    logic [AW-1:0] mark_addr;
    logic          busy1;
    logic          busy2;
    logic [AW:0]   busy_cnt;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr1    (raddr1),
        .raddr2    (raddr2),
        .rdata1    (rdata1),
        .rdata2    (rdata2),
        .mark_en   (mark_en),
        .mark_addr (mark_addr),
        .busy1     (busy1),
        .busy2     (busy2),
        .busy_cnt  (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // check mask bits
    localparam logic [4:0] C_R1  = 5'b00001;
    localparam logic [4:0] C_B1  = 5'b00010;
    localparam logic [4:0] C_R2  = 5'b00100;
    localparam logic [4:0] C_B2  = 5'b01000;
    localparam logic [4:0] C_CNT = 5'b10000;
    localparam logic [4:0] C_ALL = 5'b11111;

    typedef struct {
        string       name;
        logic [4:0]  mask;
        logic [31:0] r1;
        logic        b1;
        logic [31:0] r2;
        logic        b2;
        logic [5:0]  cnt;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int n_txn = 0;

    // -----------------------------------------------------------------------
    // Monitor
    // -----------------------------------------------------------------------
    task automatic chk(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s.%s actual=0x%08h required=0x%08h",
                     name, field, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_txn++;
            $display("txn %0d %-12s ra1=%0d rd1=0x%08h b1=%0b ra2=%0d rd2=0x%08h b2=%0b cnt=%0d",
                     n_txn, e.name, raddr1, rdata1, busy1, raddr2, rdata2,
                     busy2, busy_cnt);
            if ((e.mask & C_R1)  != 0) chk(e.name, "rdata1",   rdata1, e.r1);
            if ((e.mask & C_B1)  != 0) chk(e.name, "busy1",    {31'd0, busy1}, {31'd0, e.b1});
            if ((e.mask & C_R2)  != 0) chk(e.name, "rdata2",   rdata2, e.r2);
            if ((e.mask & C_B2)  != 0) chk(e.name, "busy2",    {31'd0, busy2}, {31'd0, e.b2});
            if ((e.mask & C_CNT) != 0) chk(e.name, "busy_cnt", {26'd0, busy_cnt}, {26'd0, e.cnt});
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic drive(input logic w, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic m,
                         input logic [AW-1:0] ma, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2);
        we        = w;
        waddr     = wa;
        wdata     = wd;
        mark_en   = m;
        mark_addr = ma;
        raddr1    = a1;
        raddr2    = a2;
    endtask

    task automatic expect_out(input string name, input logic [4:0] mask,
                              input logic [31:0] r1, input logic b1,
                              input logic [31:0] r2, input logic b2,
                              input logic [5:0] cnt);
        exp_t e;
        e.name = name;
        e.mask = mask;
        e.r1   = r1;
        e.b1   = b1;
        e.r2   = r2;
        e.b2   = b2;
        e.cnt  = cnt;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // -----------------------------------------------------------------------
    // Directed sequence
    // -----------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        step();
        step();
        rst = 1'b0;

        // reset state
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd31);
        expect_out("reset", C_ALL, 32'd0, 1'b0, 32'd0, 1'b0, 6'd0);
        step();

        // write r5 with same-cycle bypass on port 2
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd5);
        expect_out("wr5_bypass", C_ALL, 32'd0, 1'b0, 32'hDEADBEEF, 1'b0, 6'd0);
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd6);
        expect_out("rd5", C_ALL, 32'hDEADBEEF, 1'b0, 32'd0, 1'b0, 6'd0);
        step();

        // write and mark r0 are ignored
        drive(1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 5'd0, 5'd0);
        expect_out("r0_wr_mark", C_ALL, 32'd0, 1'b0, 32'd0, 1'b0, 6'd0);
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd5);
        expect_out("r0_after", C_ALL, 32'd0, 1'b0, 32'hDEADBEEF, 1'b0, 6'd0);
        step();

        // mark 3, mark 7, mark 3 again
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd7);
        expect_out("mark3", C_ALL, 32'd0, 1'b0, 32'd0, 1'b0, 6'd0);
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd3, 5'd7);
        expect_out("mark7", C_ALL, 32'd0, 1'b1, 32'd0, 1'b0, 6'd1);
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd7);
        expect_out("remark3", C_ALL, 32'd0, 1'b1, 32'd0, 1'b1, 6'd2);
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd3);
        expect_out("same_port", C_ALL, 32'd0, 1'b1, 32'd0, 1'b1, 6'd2);
        step();

        // write-back of r3 masks busy in the same cycle, count drops next
        drive(1'b1, 5'd3, 32'h0000000A, 1'b0, 5'd0, 5'd3, 5'd7);
        expect_out("wb3", C_ALL, 32'h0000000A, 1'b0, 32'd0, 1'b1, 6'd2);
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd7);
        expect_out("wb3_after", C_ALL, 32'h0000000A, 1'b0, 32'd0, 1'b1, 6'd1);
        step();

        // write and mark the same register: mark wins
        drive(1'b1, 5'd9, 32'h00000055, 1'b1, 5'd9, 5'd9, 5'd0);
        expect_out("wm9", C_ALL, 32'h00000055, 1'b0, 32'd0, 1'b0, 6'd1);
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd9);
        expect_out("wm9_after", C_ALL, 32'h00000055, 1'b1, 32'h00000055, 1'b1, 6'd2);
        step();

        // write r7 and mark r12 in the same cycle
        drive(1'b1, 5'd7, 32'h00000077, 1'b1, 5'd12, 5'd7, 5'd12);
        expect_out("w7_m12", C_ALL, 32'h00000077, 1'b0, 32'd0, 1'b0, 6'd2);
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd12);
        expect_out("w7_m12_after", C_ALL, 32'h00000077, 1'b0, 32'd0, 1'b1, 6'd2);
        step();

        // writing a non-pending register keeps it non-pending
        drive(1'b1, 5'd20, 32'h00000020, 1'b0, 5'd0, 5'd0, 5'd0);
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd20, 5'd12);
        expect_out("w20_after", C_ALL, 32'h00000020, 1'b0, 32'd0, 1'b1, 6'd2);
        step();

        // write i to ri and mark every register
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, AW'(i), DW'(i), 1'b1, AW'(i), AW'(i), 5'd0);
            expect_out("fill", C_R1 | C_B1, DW'(i), 1'b0, 32'd0, 1'b0, 6'd0);
            step();
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd31, 5'd1);
        expect_out("full", C_ALL, 32'h0000001F, 1'b1, 32'h00000001, 1'b1, 6'd31);
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd20, 5'd5);
        expect_out("full_rd", C_ALL, 32'h00000014, 1'b1, 32'h00000005, 1'b1, 6'd31);
        step();

        // reset mid-operation, with a write and a mark offered on that edge
        rst = 1'b1;
        drive(1'b1, 5'd4, 32'hFFFF0000, 1'b1, 5'd6, 5'd4, 5'd6);
        step();
        rst = 1'b0;
        for (int i = 0; i < 32; i += 2) begin
            drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, AW'(i), AW'(i + 1));
            expect_out("post_rst", C_ALL, 32'd0, 1'b0, 32'd0, 1'b0, 6'd0);
            step();
        end

        // drain the scoreboard, bounded
        for (int t = 0; t < 20 && exp_q.size() > 0; t++) begin
            step();
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain actual=%0d entries left required=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // global time limit
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "time limit");
    end

endmodule
